// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner IDs and
// the byte-to-word address shift.
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the port arbiter.
// The slave modport is the arbiter; master is the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned XLEN   = 32
);

    logic              IReq;
    logic [XLEN-1:0]   IAddr;
    logic              IValid;
    logic [XLEN-1:0]   IRData;
    logic              DReq;
    logic              DWe;
    logic [XLEN-1:0]   DAddr;
    logic [XLEN-1:0]   DWData;
    logic              DValid;
    logic [XLEN-1:0]   DRData;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [XLEN-1:0]   MemWData;
    logic [XLEN-1:0]   MemRData;
    logic              Busy;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData,
        output IValid, IRData, DValid, DRData, MemWE, MemAddr, MemWData, Busy
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData,
        input  IValid, IRData, DValid, DRData, MemWE, MemAddr, MemWData, Busy
    );

endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner selection between fetch and data requests.
// ARB_ROUND_ROBIN_EN: contention goes to the requester not served last.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic ireq,
    input  logic dreq,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic owner
);

    always_comb begin
        owner = OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (ireq && dreq) begin
            owner = ~last_owner;
        end else if (dreq) begin
            owner = OWN_D;
        end
`else
        if (dreq) begin
            owner = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto one single-port memory, one access
// per three cycles. Optional ARB_ROUND_ROBIN_EN alternates owners under contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned XLEN   = 32
) (
    input logic               CLK,
    input logic               RESET,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned AddrHi = ADDR_W + WORD_SHIFT - 1;

    logic [1:0] state;
    logic       owner;
    logic       is_store;
    logic       win;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_owner;
`endif

    mem_arb_select u_select (
        .ireq       (bus.IReq),
        .dreq       (bus.DReq),
`ifdef ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .owner      (win)
    );

    // Byte-lane and above-depth address bits are deliberately discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.IAddr[XLEN-1:AddrHi+1], bus.IAddr[WORD_SHIFT-1:0],
                                bus.DAddr[XLEN-1:AddrHi+1], bus.DAddr[WORD_SHIFT-1:0]};

    assign bus.Busy = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            owner        <= OWN_I;
            is_store     <= 1'b0;
            bus.IValid   <= 1'b0;
            bus.DValid   <= 1'b0;
            bus.MemWE    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemWData <= '0;
            bus.IRData   <= '0;
            bus.DRData   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner   <= OWN_I;
`endif
        end else begin
            bus.IValid <= 1'b0;
            bus.DValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.IReq || bus.DReq) begin
                        owner        <= win;
                        is_store     <= (win == OWN_D) && bus.DWe;
                        bus.MemWE    <= (win == OWN_D) && bus.DWe;
                        bus.MemWData <= bus.DWData;
                        bus.MemAddr  <= (win == OWN_D) ? bus.DAddr[AddrHi:WORD_SHIFT]
                                                       : bus.IAddr[AddrHi:WORD_SHIFT];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.MemWE <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (owner == OWN_I) begin
                        bus.IRData <= bus.MemRData;
                        bus.IValid <= 1'b1;
                    end else begin
                        if (!is_store) begin
                            bus.DRData <= bus.MemRData;
                        end
                        bus.DValid <= 1'b1;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner <= owner;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read memory model and a
// scoreboard of expected responses. Honors ARB_ROUND_ROBIN_EN for contention order.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        d;
        logic [31:0] data;
    } rec_t;

    logic CLK;
    logic RESET;

    mem_port_arbiter_if #(.ADDR_W(6), .XLEN(32)) bus ();

    mem_port_arbiter #(.ADDR_W(6), .XLEN(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory: write and registered read at the same edge, cleared by reset.
    logic [31:0] mem [64];
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            bus.MemRData <= '0;
        end else begin
            if (bus.MemWE) mem[bus.MemAddr] <= bus.MemWData;
            bus.MemRData <= mem[bus.MemAddr];
        end
    end

    rec_t        sb [$];
    rec_t        obs [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_drdata = '0;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (bus.IValid) obs.push_back('{1'b0, bus.IRData});
            if (bus.DValid) obs.push_back('{1'b1, bus.DRData});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drain(input string tag);
        rec_t o;
        rec_t e;
        chk({tag, "_resp_count"}, obs.size(), sb.size());
        while (obs.size() > 0 && sb.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            chk({tag, "_owner"}, {31'd0, o.d}, {31'd0, e.d});
            chk({tag, "_data"}, o.data, e.data);
        end
        obs.delete();
        sb.delete();
    endtask

    task automatic push_exp(input bit d, input bit we, input logic [31:0] rexp);
        if (d && we) begin
            sb.push_back('{1'b1, exp_drdata});
        end else begin
            sb.push_back('{d, rexp});
            if (d) exp_drdata = rexp;
        end
    endtask

    // Single access issued at posedge+1; checks latency, MemWE width, MemAddr, Busy.
    task automatic run_req(input bit d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rexp,
                           input string tag);
        int         vcyc   = 0;
        int         we_cnt = 0;
        logic [5:0] maddr  = '0;
        if (d) begin
            bus.DReq = 1'b1; bus.DWe = we; bus.DAddr = addr; bus.DWData = wdata;
        end else begin
            bus.IReq = 1'b1; bus.IAddr = addr;
        end
        push_exp(d, we, rexp);
        for (int i = 1; i <= 8 && vcyc == 0; i++) begin
            @(negedge CLK);
            if (bus.MemWE) we_cnt++;
            if (i == 2) begin
                maddr = bus.MemAddr;
                chk({tag, "_busy_issue"}, {31'd0, bus.Busy}, 32'd1);
            end
            if (i == 3) chk({tag, "_busy_wait"}, {31'd0, bus.Busy}, 32'd1);
            if (d ? bus.DValid : bus.IValid) begin
                vcyc = i;
                chk({tag, "_busy_idle"}, {31'd0, bus.Busy}, 32'd0);
                bus.IReq = 1'b0; bus.DReq = 1'b0; bus.DWe = 1'b0;
            end
        end
        chk({tag, "_latency"}, vcyc, 4);
        chk({tag, "_we_cycles"}, we_cnt, (d && we) ? 1 : 0);
        chk({tag, "_memaddr"}, {26'd0, maddr}, {26'd0, addr[7:2]});
        @(posedge CLK); #1;
        drain(tag);
    endtask

    initial begin
        int ic;
        int dc;
        int v1;
        int v2;
        int nv;

        RESET = 1'b1;
        bus.IReq = 1'b0; bus.IAddr = '0;
        bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWData = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ivalid", {31'd0, bus.IValid}, 32'd0);
        chk("rst_dvalid", {31'd0, bus.DValid}, 32'd0);
        chk("rst_memwe", {31'd0, bus.MemWE}, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_memaddr", {26'd0, bus.MemAddr}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;

        run_req(1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_0000, 32'h0, "st_w0");
        run_req(1'b1, 1'b1, 32'h0000_0008, 32'h0050_0093, 32'h0, "st_w2");
        run_req(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0050_0093, "fetch");
        run_req(1'b1, 1'b1, 32'h0000_001C, 32'hDEAD_BEEF, 32'h0, "st_w7");
        run_req(1'b1, 1'b0, 32'h0000_001C, 32'h0, 32'hDEAD_BEEF, "ld_w7");

        // Contention right after a data access: last owner is D.
        bus.IReq = 1'b1; bus.IAddr = 32'h8;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h1C;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 1'b0, 32'h0050_0093);
        push_exp(1'b1, 1'b0, 32'hDEAD_BEEF);
`else
        push_exp(1'b1, 1'b0, 32'hDEAD_BEEF);
        push_exp(1'b0, 1'b0, 32'h0050_0093);
`endif
        ic = 0; dc = 0;
        for (int i = 1; i <= 12 && (ic == 0 || dc == 0); i++) begin
            @(negedge CLK);
            if (bus.IValid) begin ic = i; bus.IReq = 1'b0; end
            if (bus.DValid) begin dc = i; bus.DReq = 1'b0; end
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk("cont_first_i", ic, 4);
        chk("cont_second_d", dc, 7);
`else
        chk("cont_first_d", dc, 4);
        chk("cont_second_i", ic, 7);
`endif
        @(posedge CLK); #1;
        drain("cont");

        run_req(1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'hCAFE_0000, "wrap");

        // Held fetch: second acceptance three cycles after the first.
        bus.IReq = 1'b1; bus.IAddr = 32'h8;
        push_exp(1'b0, 1'b0, 32'h0050_0093);
        push_exp(1'b0, 1'b0, 32'h0050_0093);
        v1 = 0; v2 = 0; nv = 0;
        for (int i = 1; i <= 12 && v2 == 0; i++) begin
            @(negedge CLK);
            if (bus.IValid) begin
                nv++;
                if (nv == 1) begin
                    v1 = i;
                    chk("held_busy_idle", {31'd0, bus.Busy}, 32'd0);
                end else begin
                    v2 = i;
                    bus.IReq = 1'b0;
                end
            end else if (v1 != 0 && (i == v1 + 1 || i == v1 + 2)) begin
                chk("held_busy_2nd", {31'd0, bus.Busy}, 32'd1);
            end
        end
        chk("held_first", v1, 4);
        chk("held_second", v2, 7);
        @(posedge CLK); #1;
        drain("held");

        run_req(1'b1, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 32'h0, "st_w4");
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h55AA_55AA, "ld_w4");

        // Reset in ISSUE of a store: the store is dropped and nothing responds.
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h10; bus.DWData = 32'h1234_5678;
        @(posedge CLK); #1;
        chk("rst_mid_memwe_pre", {31'd0, bus.MemWE}, 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        chk("rst_mid_memwe", {31'd0, bus.MemWE}, 32'd0);
        chk("rst_mid_memaddr", {26'd0, bus.MemAddr}, 32'd0);
        chk("rst_mid_memwdata", bus.MemWData, 32'd0);
        chk("rst_mid_irdata", bus.IRData, 32'd0);
        chk("rst_mid_drdata", bus.DRData, 32'd0);
        chk("rst_mid_dvalid", {31'd0, bus.DValid}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
        bus.DReq = 1'b0; bus.DWe = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        exp_drdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        drain("rst_quiet");
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, "ld_w4_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the instruction-fetch requester and the load/store requester of the multi-cycle core.
- Serialises requests and translates byte addresses to word indices.
- Drives the memory's WriteEnable/Address/WriteData for exactly one cycle per access.
- Returns read data or a write acknowledge with a one-cycle Valid pulse.

Parameters:
- ADDR_W, 6, word-index width; memory depth is 2**ADDR_W, which must equal the memory's MEMORY_SIZE.
- XLEN, 32, data and byte-address width.

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- IReq  input  1  fetch request; level, held until IValid
- IAddr  input  XLEN  fetch byte address
- IValid  output  1  one-cycle pulse; IRData valid
- IRData  output  XLEN  fetched word
- DReq  input  1  data request; level, held until DValid
- DWe  input  1  1 = store, 0 = load; sampled with DReq
- DAddr  input  XLEN  data byte address
- DWData  input  XLEN  store data
- DValid  output  1  one-cycle pulse; load data valid, or store done
- DRData  output  XLEN  load word
- MemWE  output  1  to memory WriteEnable
- MemAddr  output  ADDR_W  to memory Address (word index)
- MemWData  output  XLEN  to memory WriteData
- MemRData  input  XLEN  from memory ReadData (registered, 1-cycle)
- Busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; IValid, DValid, MemWE = 0; MemAddr, MemWData, IRData, DRData = 0; any in-flight transaction is dropped with no Valid.
- FSM: IDLE -> ISSUE -> WAIT -> IDLE. All outputs are registered.
- IDLE: if either request is present at edge N, choose a winner and latch:
  - Owner flag.
  - MemAddr = Addr[ADDR_W+1:2].
  - MemWData = DWData.
  - MemWE = DWe if data wins, 0 if fetch wins.
  - Go to ISSUE.
- Addr[1:0] and the upper address bits are ignored; out-of-range addresses wrap modulo depth.
- ISSUE (memory acts at edge N+1): clear MemWE at N+1, so MemWE is high for exactly one cycle. Go to WAIT.
- WAIT (edge N+2):
  - Fetch owner: IRData <= MemRData, IValid <= 1.
  - Load owner: DRData <= MemRData, DValid <= 1.
  - Store owner: DValid <= 1, DRData unchanged.
  - Go to IDLE.
- Latency: Valid is high in the cycle after edge N+2. Next acceptance is possible at edge N+3. Maximum throughput is one access per 3 cycles.
- Valid pulses last exactly one cycle. A requester must drop Req in its Valid cycle; a Req still high at the following edge is a new request.
- Requests arriving while Busy are ignored until IDLE. They are not queued; the level must be held.
- MemAddr and MemWData hold their last values outside ISSUE.
- Simultaneous IReq and DReq in IDLE: data wins (the core only fetches after a load/store retires). The loser stays pending and is served next.
- A request dropped while Busy does not abort the access; its Valid still pulses.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: a last-owner register (reset value = fetch) resolves simultaneous requests in favour of the requester not served last, so they alternate.
- Not defined: fixed data-over-fetch priority; no last-owner register.
- The single-requester path is identical in both builds.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Owner encoding: OWN_I=1'b0, OWN_D=1'b1.
  - Byte-to-word shift constant WORD_SHIFT=2.
- One natural sub-module, mem_arb_select: combinational winner selection from IReq, DReq and the last owner. It isolates the ARB_ROUND_ROBIN_EN variation.

Test Plan:
- Reset: assert RESET mid-ISSUE of a store to 0x10 -> all outputs 0, no DValid. Memory and arbiter reset together, so word 4 reads back 0.
- Fetch: IReq=1, IAddr=0x08 after word 2 is preloaded with 0x00500093 -> MemAddr=2 and MemWE=0 at N+1; IValid pulse with IRData=0x00500093 after N+2.
- Store then load: DWe=1, DAddr=0x1C, DWData=0xDEADBEEF -> MemWE high exactly one cycle, MemAddr=7, DValid pulse. Then DWe=0, DAddr=0x1C -> DRData=0xDEADBEEF.
- Contention: IReq and DReq both asserted at the same edge -> D served first, I served at N+3; IValid 3 cycles after DValid. With ARB_ROUND_ROBIN_EN and last owner = D, I is served first.
- Wrap and alignment: DAddr=0x103 load with ADDR_W=6 -> MemAddr=0 (index 64 wraps to 0).
- Held request: keep IReq high through IValid -> second fetch accepted at N+3; Busy=1 through ISSUE and WAIT and 0 in IDLE.
